// File: rtl/spi_peripheral_pkg.sv
// Shared SPI types: state encoding and byte width for the SPI peripheral.
package spi_peripheral_pkg;

    localparam int SPI_BYTE_BITS = 8;

    typedef logic [0:0] spi_peripheral_state_t;

    localparam spi_peripheral_state_t S_IDLE  = 1'b0;
    localparam spi_peripheral_state_t S_SHIFT = 1'b1;

endpackage

// File: rtl/spi_peripheral_synchronizer.sv
// Multi-flop synchronizer for one asynchronous input bit.
module spi_peripheral_synchronizer #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) chain <= {STAGES{RESET_VAL}};
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder: oversampled pins, MSB-first RX to valid/ready, one-deep TX buffer to miso.
//
// state   | meaning
// S_IDLE  | deselected (or not yet armed); miso held low, waiting for csb to fall
// S_SHIFT | selected; sample mosi on sclk rise, drive miso on sclk fall
module spi_peripheral
    import spi_peripheral_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       csb,
    input  logic       mosi,
    output logic       miso,
    output logic       i_ready,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    input  logic       o_ready,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_first,
    output logic       o_overrun,
    output logic       tx_underrun,
    output logic [2:0] bit_counter
);

    localparam int PW = $clog2(SYNC_STAGES + 1);

    logic csb_s, sclk_s, mosi_s, sclk_d;
    logic rise, fall;

    spi_peripheral_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
        .clk(clk), .rst(rst), .d(csb), .q(csb_s)
    );
    spi_peripheral_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
    );
    spi_peripheral_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
    );

    always_ff @(posedge clk) begin
        if (rst) sclk_d <= 1'b0;
        else     sclk_d <= sclk_s;
    end

    assign rise = sclk_s & ~sclk_d;
    assign fall = ~sclk_s & sclk_d;

    // The csb chain resets to 1, so arming waits until the chain holds real pin samples;
    // otherwise a reset during an active transaction would re-arm on stale reset values.
    logic [PW-1:0] prime_cnt;
    logic          armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt <= PW'(SYNC_STAGES);
            armed     <= 1'b0;
        end else begin
            if (prime_cnt != '0) prime_cnt <= prime_cnt - 1'b1;
            if (prime_cnt == '0 && csb_s) armed <= 1'b1;
        end
    end

    spi_peripheral_state_t    state;
    logic [7:0]               tx_shift;
    logic [SPI_BYTE_BITS-1:0] rx_shift;
    logic [SPI_BYTE_BITS-1:0] rx_next;
    logic                     load_pending;
    logic                     first_flag;
    logic                     buf_full;
    logic [7:0]               buf_data;
    logic                     idle_exit, shift_load, do_load, wr;
    logic [7:0]               load_byte;

    assign idle_exit  = (state == S_IDLE) && !csb_s && armed;
    assign shift_load = (state == S_SHIFT) && !csb_s && fall && load_pending;
    assign do_load    = idle_exit | shift_load;
    assign load_byte  = buf_full ? buf_data : FILL_BYTE;
    assign rx_next    = {rx_shift[SPI_BYTE_BITS-2:0], mosi_s};
    assign i_ready    = ~buf_full;
    assign wr         = i_valid & i_ready;

    // A write can only land while the buffer is empty, so a same-cycle load has already taken FILL_BYTE.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_data <= 8'h00;
        end else if (wr) begin
            buf_full <= 1'b1;
            buf_data <= i_data;
        end else if (do_load) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            miso         <= 1'b0;
            o_valid      <= 1'b0;
            o_data       <= 8'h00;
            o_first      <= 1'b0;
            o_overrun    <= 1'b0;
            tx_underrun  <= 1'b0;
            bit_counter  <= 3'd7;
            tx_shift     <= 8'h00;
            rx_shift     <= '0;
            load_pending <= 1'b0;
            first_flag   <= 1'b0;
        end else begin
            o_overrun   <= 1'b0;
            tx_underrun <= 1'b0;
            if (o_valid && o_ready) o_valid <= 1'b0;

            if (do_load) begin
                tx_shift    <= load_byte;
                miso        <= load_byte[7];
                tx_underrun <= ~buf_full;
            end

            case (state)
                S_IDLE: begin
                    if (idle_exit) begin
                        bit_counter <= 3'd7;
                        first_flag  <= 1'b1;
                        state       <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (csb_s) begin
                        state        <= S_IDLE;
                        miso         <= 1'b0;
                        load_pending <= 1'b0;
                    end else if (rise) begin
                        rx_shift <= rx_next;
                        if (bit_counter == 3'd0) begin
                            o_data       <= rx_next;
                            o_valid      <= 1'b1;
                            o_first      <= first_flag;
                            o_overrun    <= o_valid & ~o_ready;
                            first_flag   <= 1'b0;
                            bit_counter  <= 3'd7;
                            load_pending <= 1'b1;
                        end else begin
                            bit_counter <= bit_counter - 3'd1;
                        end
                    end else if (fall) begin
                        if (load_pending) load_pending <= 1'b0;
                        else              miso         <= tx_shift[bit_counter];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Testbench for spi_peripheral: a behavioural mode-0 main plus a byte-level reference model.
module tb_spi_peripheral;
    import spi_peripheral_pkg::*;

    localparam int         HALF = 80;
    localparam logic [7:0] FILL = 8'h00;

    logic       clk = 1'b0;
    logic       rst, sclk, csb, mosi, miso;
    logic       i_ready, i_valid, o_ready, o_valid, o_first, o_overrun, tx_underrun;
    logic [7:0] i_data, o_data;
    logic [2:0] bit_counter;

    int checks = 0;
    int fails  = 0;
    int ovr_cnt = 0;
    int und_cnt = 0;
    logic [8:0] rx_q[$];
    logic [7:0] mosi_q[$];
    logic [7:0] miso_q[$];

    spi_peripheral #(.SYNC_STAGES(2), .FILL_BYTE(FILL)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .csb(csb), .mosi(mosi), .miso(miso),
        .i_ready(i_ready), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_first(o_first),
        .o_overrun(o_overrun), .tx_underrun(tx_underrun), .bit_counter(bit_counter)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_valid && o_ready) rx_q.push_back({o_first, o_data});
        if (o_overrun) ovr_cnt++;
        if (tx_underrun) und_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Mode-0 main: mosi changes with sclk fall, miso sampled on rise; final fall coincides with csb rise.
    task automatic spi_xfer(input int stop_bits);
        int         lim;
        logic [7:0] rd;
        logic [7:0] nb;
        lim = (stop_bits > 0) ? stop_bits : mosi_q.size() * 8;
        rd  = 8'h00;
        miso_q.delete();
        @(posedge clk); #2;
        nb   = mosi_q[0];
        csb  = 1'b0;
        mosi = nb[7];
        #HALF;
        for (int k = 0; k < lim; k++) begin
            sclk = 1'b1;
            rd   = {rd[6:0], miso};
            if (k % 8 == 7) miso_q.push_back(rd);
            #HALF;
            sclk = 1'b0;
            if (k == lim - 1) begin
                csb  = 1'b1;
                mosi = 1'b0;
            end else begin
                nb   = mosi_q[(k + 1) / 8];
                mosi = nb[7 - ((k + 1) % 8)];
            end
            #HALF;
        end
        #(2 * HALF);
    endtask

    task automatic tx_write(input logic [7:0] d);
        int n = 0;
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_data  = d;
        while (!i_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!i_ready) begin
            checks++; fails++;
            $display("FAIL tx_write_timeout: i_ready=%b required 1", i_ready);
        end else begin
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
        checks++; if (o_data !== 8'h00) begin fails++; $display("FAIL reset_o_data: got %h want 00", o_data); end
        checks++; if (o_first !== 1'b0) begin fails++; $display("FAIL reset_o_first: got %b want 0", o_first); end
        checks++; if ({o_overrun, tx_underrun} !== 2'b00) begin fails++; $display("FAIL reset_pulses: got %b want 00", {o_overrun, tx_underrun}); end
        checks++; if (bit_counter !== 3'd7) begin fails++; $display("FAIL reset_bit_counter: got %0d want 7", bit_counter); end
        checks++; if (miso !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b want 0", miso); end
        checks++; if (i_ready !== 1'b1) begin fails++; $display("FAIL reset_i_ready: got %b want 1", i_ready); end
        checks++; if (dut.state !== S_IDLE) begin fails++; $display("FAIL reset_state: got %b want %b", dut.state, S_IDLE); end
    endtask

    task automatic test_write8();
        rx_q.delete(); und_cnt = 0;
        mosi_q = '{8'hA5};
        spi_xfer(0);
        checks++; if (rx_q.size() !== 1) begin fails++; $display("FAIL w8_rx_count: got %0d want 1", rx_q.size()); end
        checks++; if (rx_q[0] !== {1'b1, 8'hA5}) begin fails++; $display("FAIL w8_rx_byte: got %h want 1a5", rx_q[0]); end
        checks++; if (und_cnt !== 1) begin fails++; $display("FAIL w8_underrun: got %0d want 1", und_cnt); end
        checks++; if (miso_q.size() !== 1 || miso_q[0] !== FILL) begin fails++; $display("FAIL w8_miso: got %h want %h", miso_q[0], FILL); end
    endtask

    task automatic test_full_duplex();
        tx_write(8'h3C);
        rx_q.delete(); und_cnt = 0;
        mosi_q = '{8'h9F, FILL};
        fork
            spi_xfer(0);
            tx_write(8'hC3);
        join
        checks++; if (miso_q.size() !== 2) begin fails++; $display("FAIL fd_miso_count: got %0d want 2", miso_q.size()); end
        checks++; if (miso_q[0] !== 8'h3C) begin fails++; $display("FAIL fd_miso_cmd: got %h want 3c", miso_q[0]); end
        checks++; if (miso_q[1] !== 8'hC3) begin fails++; $display("FAIL fd_miso_read: got %h want c3", miso_q[1]); end
        checks++; if (rx_q.size() !== 2) begin fails++; $display("FAIL fd_rx_count: got %0d want 2", rx_q.size()); end
        checks++; if (rx_q[0] !== {1'b1, 8'h9F}) begin fails++; $display("FAIL fd_rx0: got %h want 19f", rx_q[0]); end
        checks++; if (rx_q[1] !== {1'b0, FILL}) begin fails++; $display("FAIL fd_rx1: got %h want 0%h", rx_q[1], FILL); end
        checks++; if (und_cnt !== 0) begin fails++; $display("FAIL fd_underrun: got %0d want 0", und_cnt); end
    endtask

    task automatic test_overrun();
        @(posedge clk); #1;
        o_ready = 1'b0;
        rx_q.delete(); ovr_cnt = 0;
        mosi_q = '{8'h12, 8'h34};
        spi_xfer(0);
        checks++; if (o_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid: got %b want 1", o_valid); end
        checks++; if (o_data !== 8'h34) begin fails++; $display("FAIL ovr_data: got %h want 34", o_data); end
        checks++; if (o_first !== 1'b0) begin fails++; $display("FAIL ovr_first: got %b want 0", o_first); end
        checks++; if (ovr_cnt !== 1) begin fails++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (o_valid !== 1'b1) begin fails++; $display("FAIL ovr_hold: got %b want 1", o_valid); end
        o_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL ovr_release: got %b want 0", o_valid); end
        rx_q.delete();
    endtask

    task automatic test_partial();
        rx_q.delete();
        mosi_q = '{8'hFF};
        spi_xfer(5);
        checks++; if (rx_q.size() !== 0) begin fails++; $display("FAIL part_rx_count: got %0d want 0", rx_q.size()); end
        checks++; if (miso !== 1'b0) begin fails++; $display("FAIL part_miso: got %b want 0", miso); end
        checks++; if (dut.state !== S_IDLE) begin fails++; $display("FAIL part_state: got %b want %b", dut.state, S_IDLE); end
        mosi_q = '{8'h5A};
        spi_xfer(0);
        checks++; if (rx_q.size() !== 1 || rx_q[0] !== {1'b1, 8'h5A}) begin fails++; $display("FAIL part_follow: got %h (n=%0d) want 15a", rx_q[0], rx_q.size()); end
    endtask

    task automatic test_reset_mid();
        rx_q.delete();
        mosi_q = '{8'hE7};
        fork
            spi_xfer(0);
            begin
                #(HALF * 6);
                do_reset();
            end
        join
        checks++; if (rx_q.size() !== 0) begin fails++; $display("FAIL rstmid_rx_count: got %0d want 0", rx_q.size()); end
        checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b want 0", o_valid); end
        mosi_q = '{8'h77};
        spi_xfer(0);
        checks++; if (rx_q.size() !== 1 || rx_q[0] !== {1'b1, 8'h77}) begin fails++; $display("FAIL rstmid_next: got %h (n=%0d) want 177", rx_q[0], rx_q.size()); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int         n;
            int         pre;
            logic [7:0] pb;
            logic [7:0] exp_miso;
            n   = $urandom_range(1, 3);
            pre = $urandom_range(0, 1);
            pb  = 8'($urandom);
            mosi_q.delete();
            for (int k = 0; k < n; k++) mosi_q.push_back(8'($urandom));
            if (pre == 1) tx_write(pb);
            rx_q.delete(); und_cnt = 0;
            spi_xfer(0);
            checks++; if (rx_q.size() !== n) begin fails++; $display("FAIL rnd%0d_rx_count: got %0d want %0d", t, rx_q.size(), n); end
            checks++; if (miso_q.size() !== n) begin fails++; $display("FAIL rnd%0d_miso_count: got %0d want %0d", t, miso_q.size(), n); end
            for (int k = 0; k < n; k++) begin
                exp_miso = (k == 0 && pre == 1) ? pb : FILL;
                checks++; if (rx_q[k] !== {(k == 0), mosi_q[k]}) begin fails++; $display("FAIL rnd%0d_rx%0d: got %h want %h", t, k, rx_q[k], {(k == 0), mosi_q[k]}); end
                checks++; if (miso_q[k] !== exp_miso) begin fails++; $display("FAIL rnd%0d_miso%0d: got %h want %h", t, k, miso_q[k], exp_miso); end
            end
            checks++; if (und_cnt !== n - pre) begin fails++; $display("FAIL rnd%0d_underrun: got %0d want %0d", t, und_cnt, n - pre); end
            checks++; if (i_ready !== 1'b1) begin fails++; $display("FAIL rnd%0d_i_ready: got %b want 1", t, i_ready); end
        end
    endtask

    initial begin
        rst = 1'b0; sclk = 1'b0; csb = 1'b1; mosi = 1'b0;
        i_valid = 1'b0; i_data = 8'h00; o_ready = 1'b1;
        test_reset();
        test_write8();
        test_full_duplex();
        test_overrun();
        test_partial();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
